// File: rtl/pad_poll_sequencer.sv
// Latch/pulse poll sequencer for a serial shift-register button pad.
// Frames start on a periodic tick or on request and are published through valid/ready.
module pad_poll_sequencer #(
  parameter int NUM_BITS     = 8,
  parameter int POLL_PERIOD  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data,
  input  logic                poll_req,
  output logic                latch,
  output logic                pulse,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  input  logic                buttons_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int BW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t              state;
  logic [1:0]          sync;
  logic [PW-1:0]       pcount;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bidx;
  logic [NUM_BITS-1:0] sr;
  logic                pending;
  logic                tick;
  logic                trig;

  assign tick = (pcount == PERIOD_LAST);
  assign trig = tick || poll_req || pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sync          <= 2'b11;
      pcount        <= '0;
      cnt           <= '0;
      bidx          <= '0;
      sr            <= '1;
      pending       <= 1'b0;
      latch         <= 1'b0;
      pulse         <= 1'b0;
      buttons       <= '1;
      buttons_valid <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync    <= {sync[0], data};
      pcount  <= tick ? '0 : pcount + 1'b1;
      overrun <= 1'b0;
      if (buttons_valid && buttons_ready) buttons_valid <= 1'b0;
      // Requests while a frame runs collapse into one deferred poll.
      if (state != IDLE && (tick || poll_req)) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trig) begin
            state   <= LATCH;
            latch   <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
            cnt     <= '0;
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            state <= LOW;
            latch <= 1'b0;
            cnt   <= '0;
            bidx  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt == HALF_LAST) begin
            // Sample at the end of the low phase, the latest point the pad data is stable.
            sr  <= {sr[NUM_BITS-2:0], sync[1]};
            cnt <= '0;
            if (bidx == BIT_LAST) begin
              state <= DONE;
            end else begin
              state <= HIGH;
              pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == HALF_LAST) begin
            state <= LOW;
            pulse <= 1'b0;
            bidx  <= bidx + 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          buttons       <= sr;
          buttons_valid <= 1'b1;
          overrun       <= buttons_valid && !buttons_ready;
        end
        default: begin
          state <= IDLE;
          latch <= 1'b0;
          pulse <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_poll_sequencer.sv
// Directed bench for pad_poll_sequencer with a behavioural shift-register pad.
// Small timing parameters give a 50-cycle frame and a 200-cycle poll period.
module tb_pad_poll_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data;
  logic       poll_req = 1'b0;
  logic       latch;
  logic       pulse;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       buttons_ready = 1'b0;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  pad_poll_sequencer #(
    .NUM_BITS(8), .POLL_PERIOD(200), .LATCH_CYCLES(4), .HALF_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .poll_req(poll_req),
    .latch(latch), .pulse(pulse), .buttons(buttons),
    .buttons_valid(buttons_valid), .buttons_ready(buttons_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pad: latch loads the pattern and presents its MSB; each pulse rise shifts the next bit out.
  logic [7:0] pattern = 8'hB2;
  logic [7:0] pad_sr  = 8'hFF;
  assign data = pad_sr[7];
  always @(posedge latch or posedge pulse) begin
    if (latch) pad_sr = pattern;
    else       pad_sr = {pad_sr[6:0], 1'b1};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int lat_n = 0, pul_n = 0, pul_r = 0, lat_r = 0, ovl = 0, ovr_n = 0, vld_n = 0;
  int last_rise = 0, prev_rise = 0;
  logic lat_q = 1'b0, pul_q = 1'b0;
  always @(negedge clk) begin
    if (latch) lat_n <= lat_n + 1;
    if (pulse) pul_n <= pul_n + 1;
    if (pulse && !pul_q) pul_r <= pul_r + 1;
    if (latch && !lat_q) begin
      lat_r     <= lat_r + 1;
      prev_rise <= last_rise;
      last_rise <= cyc;
    end
    if (latch && pulse) ovl <= ovl + 1;
    if (overrun) ovr_n <= ovr_n + 1;
    if (buttons_valid) vld_n <= vld_n + 1;
    lat_q <= latch;
    pul_q <= pulse;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 5000 && cyc < c; i++) step();
  endtask

  task automatic poll();
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!buttons_valid && k < 100) begin
      step();
      k++;
    end
  endtask

  int k, s_lat, s_pul, s_pr, s_vld, s_lr, s_ovr;

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_latch", latch, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_buttons", buttons, 8'hFF);
    chk("rst_valid", buttons_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;

    // single requested frame: timing, waveform shape, data
    run_to(9);
    s_lat = lat_n; s_pul = pul_n; s_pr = pul_r;
    poll();
    chk("t1_latch_start", latch, 1);
    chk("t1_busy_start", busy, 1);
    wait_valid(k);
    chk("t1_frame_len", k, 50);
    chk("t1_buttons", buttons, 8'hB2);
    chk("t1_busy_end", busy, 0);
    chk("t1_latch_cycles", lat_n - s_lat, 4);
    chk("t1_pulse_rises", pul_r - s_pr, 7);
    chk("t1_pulse_cycles", pul_n - s_pul, 21);
    buttons_ready = 1'b1;
    step();
    chk("t1_valid_clear", buttons_valid, 0);

    // periodic frames with ready held
    run_to(190);
    s_vld = vld_n; s_lr = lat_r;
    run_to(700);
    chk("t2_valid_cycles", vld_n - s_vld, 3);
    chk("t2_frames", lat_r - s_lr, 3);
    chk("t2_period", last_rise - prev_rise, 200);
    chk("t2_overlap", ovl, 0);

    // overrun across two unconsumed frames
    buttons_ready = 1'b0;
    pattern = 8'hFE;
    s_ovr = ovr_n;
    run_to(900);
    chk("t3_valid1", buttons_valid, 1);
    chk("t3_buttons1", buttons, 8'hFE);
    chk("t3_no_overrun", ovr_n - s_ovr, 0);
    pattern = 8'h7F;
    run_to(1100);
    chk("t3_buttons2", buttons, 8'h7F);
    chk("t3_valid2", buttons_valid, 1);
    chk("t3_overrun_once", ovr_n - s_ovr, 1);
    buttons_ready = 1'b1;
    step();
    chk("t3_valid_clear", buttons_valid, 0);

    // requests and a tick during a frame collapse into one follow-on frame
    run_to(1179);
    s_lr = lat_r;
    poll();
    run_to(1190);
    poll();
    run_to(1395);
    chk("t4_frames", lat_r - s_lr, 2);
    chk("t4_gap", last_rise - prev_rise, 51);
    chk("t4_overlap", ovl, 0);

    // frame completion coincident with a handshake
    run_to(1459);
    buttons_ready = 1'b0;
    pattern = 8'h5A;
    poll();
    run_to(1515);
    chk("t5_valid_a", buttons_valid, 1);
    chk("t5_buttons_a", buttons, 8'h5A);
    pattern = 8'hC3;
    run_to(1519);
    s_ovr = ovr_n;
    poll();
    repeat (49) step();
    chk("t5_done_busy", busy, 1);
    chk("t5_done_old", buttons, 8'h5A);
    buttons_ready = 1'b1;
    step();
    chk("t5_valid_kept", buttons_valid, 1);
    chk("t5_buttons_b", buttons, 8'hC3);
    chk("t5_overrun", overrun, 0);
    chk("t5_busy_end", busy, 0);
    step();
    chk("t5_valid_clear", buttons_valid, 0);
    chk("t5_overrun_cnt", ovr_n - s_ovr, 0);

    // reset during the fourth low phase
    buttons_ready = 1'b0;
    run_to(1659);
    poll();
    repeat (22) step();
    chk("t6_in_low", pulse, 0);
    chk("t6_in_busy", busy, 1);
    chk("t6_pre_valid", buttons_valid, 1);
    rst = 1'b1;
    step();
    chk("t6_latch", latch, 0);
    chk("t6_pulse", pulse, 0);
    chk("t6_buttons", buttons, 8'hFF);
    chk("t6_valid", buttons_valid, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b0;
    pattern = 8'h96;
    repeat (5) step();
    poll();
    wait_valid(k);
    chk("t6_frame_len", k, 50);
    chk("t6_buttons_new", buttons, 8'h96);
    chk("t6_overlap", ovl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_poll_sequencer.md
# pad_poll_sequencer

Fully synchronous poll sequencer for a serial button-pad interface (latch/pulse/data, shift-register style). It generates the latch and pulse waveforms from periodic and on-demand poll triggers and samples the serial data line with a clock enable, so no derived clocks are used. It delivers each completed frame to downstream logic through a valid/ready handshake. It sits between the pad pins and the game/application logic.

## Interface

- NUM_BITS, 8, bits per frame (buttons per pad)
- POLL_PERIOD, 833333, clk cycles between automatic polls (60 Hz at 50 MHz); must exceed frame length
- LATCH_CYCLES, 600, clk cycles latch is held high
- HALF_CYCLES, 300, clk cycles per pulse low phase and per pulse high phase

- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data  input  1  serial pad data, asynchronous to clk, active-low (0 = pressed)
- poll_req  input  1  single-cycle request for an immediate poll
- latch  output  1  latch strobe to pad
- pulse  output  1  shift clock to pad
- buttons  output  NUM_BITS  last completed frame, raw active-low; first sampled bit is at MSB
- buttons_valid  output  1  buttons holds an unconsumed frame
- buttons_ready  input  1  consumer accepts the frame when buttons_valid && buttons_ready
- busy  output  1  frame in progress (state != IDLE)
- overrun  output  1  one-cycle pulse: unconsumed frame was overwritten

## Operation

- data passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Period counter: free-running, 0..POLL_PERIOD-1, wraps to 0. tick = (count == POLL_PERIOD-1).
- Trigger = tick || poll_req || pending. A poll_req or tick arriving while busy is recorded in a 1-bit pending flag and serviced on the return to IDLE. Multiple requests while busy collapse to one. A simultaneous tick and poll_req start one frame.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
  - IDLE: trigger -> LATCH, clears pending.
  - LATCH: latch=1 for LATCH_CYCLES cycles -> LOW, bit index = 0.
  - LOW: pulse=0 for HALF_CYCLES cycles. On the last LOW cycle, shift the synchronized data into the shift register MSB-first. If bit index == NUM_BITS-1 -> DONE, else -> HIGH.
  - HIGH: pulse=1 for HALF_CYCLES cycles; bit index++ -> LOW.
  - DONE: 1 cycle. On exit, buttons <= shift register, buttons_valid <= 1 -> IDLE.
- Pulses per frame: NUM_BITS-1 (the first bit is presented by latch).
- Handshake:
  - buttons_valid clears on the edge after a cycle with valid && ready.
  - When DONE completes while valid=1 and ready=0: buttons is overwritten, valid stays 1, and overrun=1 for 1 cycle.
  - When DONE completes in the same cycle as a ready handshake: buttons gets the new frame, valid stays 1, and overrun stays 0.
- latch and pulse are registered and glitch-free. They are never high simultaneously.
- Reset values: latch 0, pulse 0, buttons all ones, buttons_valid 0, busy 0, overrun 0, state IDLE, pending 0, period counter 0, shift register all ones.
- Reset asserted mid-frame aborts the frame on the next edge. No partial frame is published.

## Timing

- Trigger seen at edge E0: latch high in cycles E0+1..E0+LATCH_CYCLES; busy high from E0+1.
- Frame length F = LATCH_CYCLES + (2*NUM_BITS-1)*HALF_CYCLES + 1 (DONE). Defaults: 600+4500+1 = 5101 cycles.
- buttons/buttons_valid update at edge E0+F. busy drops in the same cycle buttons_valid rises.
- The pad sees data changes ≥ HALF_CYCLES before each sample. Synchronizer latency is 2 cycles, so HALF_CYCLES ≥ 3 is required.
- Back-to-back frames (pending set): the next latch rises 1 cycle after IDLE is re-entered.
- Counter widths are $clog2 of their parameters. No counter may overflow at maximum parameter values.

## Test plan

- Sim params NUM_BITS=8, POLL_PERIOD=200, LATCH_CYCLES=4, HALF_CYCLES=3; pad model drives pattern 8'b1011_0010. poll_req at cycle 10 -> latch high 4 cycles, 7 pulse highs of 3 cycles each, buttons=8'hB2 with buttons_valid rising exactly F=50 cycles after trigger edge.
- No poll_req, ready=1 held -> frames start every 200 cycles; buttons_valid high exactly 1 cycle per frame.
- Hold ready=0 across two frames with patterns 8'hFE then 8'h7F -> buttons=8'h7F, valid stays 1, overrun pulses once; asserting ready then clears valid next edge.
- poll_req mid-frame plus a tick in the same frame -> exactly one extra frame starting 1 cycle after IDLE; no overlap of latch with pulse.
- Simultaneous DONE and valid&&ready -> valid stays 1, new data on buttons, overrun=0.
- rst asserted during the 4th LOW phase -> next edge: latch=0, pulse=0, buttons=8'hFF, valid=0, busy=0; a fresh poll after release yields a correct frame.
